// File: rtl/pipe_hazard_unit_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit_if
//
// Groups the ID-stage instruction fields, the forwarding data sources and the
// hazard-unit results into one bundle between the pipeline and the hazard unit.
//
// Signal summary:
//   id_valid          ID holds a real instruction
//   id_rs, id_rt      ID source register addresses
//   id_use_rs/rt      source is actually read by the ID instruction
//   id_rd, id_we      ID destination address / writes a register
//   id_load           ID instruction is a load
//   flush             branch taken in EX; squash the ID instruction
//   rf_a, rf_b        register-file read data for rs / rt
//   stage_data        result of stage k at [k*WORD_WIDTH +: WORD_WIDTH]
//   op_a, op_b        forwarded operands to ID/EX
//   stall             hold PC and IF/ID, insert a bubble
//   pc_we, ifid_we    write enables, both ~stall
//   stall_cnt         saturating count of stall cycles
//   sb_valid          debug view: valid bit of each scoreboard entry
//
// Handshake: there is no valid/ready pair here. The pipeline presents the ID
// instruction every cycle; when stall is high in a cycle, that instruction is
// not accepted and must be presented again, and when flush is high it is
// dropped. The unit answers combinationally in the same cycle.
//
// Modports:
//   master  the pipeline side (drives ID fields and data sources)
//   slave   the hazard unit
// -----------------------------------------------------------------------------
interface pipe_hazard_unit_if #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int CNT_W      = 16
);
    logic                          id_valid;
    logic [ADDR_W-1:0]             id_rs;
    logic [ADDR_W-1:0]             id_rt;
    logic                          id_use_rs;
    logic                          id_use_rt;
    logic [ADDR_W-1:0]             id_rd;
    logic                          id_we;
    logic                          id_load;
    logic                          flush;
    logic [WORD_WIDTH-1:0]         rf_a;
    logic [WORD_WIDTH-1:0]         rf_b;
    logic [DEPTH*WORD_WIDTH-1:0]   stage_data;
    logic [WORD_WIDTH-1:0]         op_a;
    logic [WORD_WIDTH-1:0]         op_b;
    logic                          stall;
    logic                          pc_we;
    logic                          ifid_we;
    logic [CNT_W-1:0]              stall_cnt;
    logic [DEPTH-1:0]              sb_valid;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_rd, id_we, id_load, flush,
        output rf_a, rf_b, stage_data,
        input  op_a, op_b, stall, pc_we, ifid_we, stall_cnt, sb_valid
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_rd, id_we, id_load, flush,
        input  rf_a, rf_b, stage_data,
        output op_a, op_b, stall, pc_we, ifid_we, stall_cnt, sb_valid
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard detection and operand forwarding for the ID stage. A scoreboard with
// one entry per stage downstream of ID (entry 0 = EX, entry DEPTH-1 = WB)
// records the destination of every instruction in flight. Each ID source is
// forwarded from the youngest in-flight producer; a source whose youngest
// producer is a load that has not yet reached stage LOAD_READY stalls IF/ID
// and a bubble enters the scoreboard instead. A taken branch (flush) squashes
// the ID instruction and overrides any stall.
//
// Ports:
//   CLK   clock, all state updates on the rising edge
//   RST   synchronous, active-high reset (clears scoreboard and counter)
//   bus   pipe_hazard_unit_if.slave (ID fields, data sources, results)
//
// Parameters:
//   WORD_WIDTH  datapath width
//   ADDR_W      register-address width
//   DEPTH       tracked stages after ID, legal 1..8
//   LOAD_READY  lowest stage index where load data is valid, legal 0..DEPTH-1
//   CNT_W       stall-counter width
// -----------------------------------------------------------------------------
module pipe_hazard_unit #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter int CNT_W      = 16
) (
    input logic              CLK,
    input logic              RST,
    pipe_hazard_unit_if.slave bus
);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic              ld;
    } sb_entry_t;

    sb_entry_t             sb [DEPTH];
    sb_entry_t             new_entry;
    logic [CNT_W-1:0]      cnt_q;

    logic [WORD_WIDTH-1:0] op_a_c;
    logic [WORD_WIDTH-1:0] op_b_c;
    logic                  haz_a;
    logic                  haz_b;
    logic                  stall_c;

    // An entry produces a value for source s only if it is a real, writing
    // instruction targeting s. Register 0 is hard-wired and never forwarded.
    function automatic logic src_match(
        input sb_entry_t         e,
        input logic [ADDR_W-1:0] s,
        input logic              use_s
    );
        return e.v && e.we && (e.rd == s) && (s != '0) && use_s;
    endfunction

    // Forwarding and load-use detection. The loop walks from the oldest
    // entry down to entry 0 so the youngest matching producer is written
    // last and wins. A younger non-load producer therefore shadows an older
    // load to the same register, clearing the hazard.
    always_comb begin
        op_a_c = bus.rf_a;
        op_b_c = bus.rf_b;
        haz_a  = 1'b0;
        haz_b  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (src_match(sb[k], bus.id_rs, bus.id_use_rs)) begin
                op_a_c = bus.stage_data[k*WORD_WIDTH +: WORD_WIDTH];
                haz_a  = sb[k].ld && (k < LOAD_READY);
            end
            if (src_match(sb[k], bus.id_rt, bus.id_use_rt)) begin
                op_b_c = bus.stage_data[k*WORD_WIDTH +: WORD_WIDTH];
                haz_b  = sb[k].ld && (k < LOAD_READY);
            end
        end
    end

    // flush wins over a hazard: the ID instruction is being squashed anyway,
    // so holding the front end would only waste a cycle.
    always_comb begin
        stall_c = bus.id_valid && !bus.flush && (haz_a || haz_b);
    end

    // Entry 0 takes the ID instruction only when it actually advances;
    // a stalled, squashed or empty ID slot enters as a bubble.
    always_comb begin
        new_entry = '0;
        if (bus.id_valid && !bus.flush && !stall_c) begin
            new_entry.v  = 1'b1;
            new_entry.rd = bus.id_rd;
            new_entry.we = bus.id_we;
            new_entry.ld = bus.id_load;
        end
    end

    // Scoreboard shift register and saturating stall counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            sb[0] <= new_entry;
            for (int k = 1; k < DEPTH; k++) begin
                sb[k] <= sb[k-1];
            end
            if (stall_c && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        bus.sb_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            bus.sb_valid[k] = sb[k].v;
        end
    end

    assign bus.op_a      = op_a_c;
    assign bus.op_b      = op_b_c;
    assign bus.stall     = stall_c;
    assign bus.pc_we     = ~stall_c;
    assign bus.ifid_we   = ~stall_c;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_unit
//
// Three instances share one stimulus stream:
//   u0  LOAD_READY=1, CNT_W=16  (defaults)
//   u1  LOAD_READY=2, CNT_W=16
//   u2  LOAD_READY=1, CNT_W=2   (counter saturation)
// The reference model keeps an issue log per instance: for every clock edge
// it records what instruction (if any) was accepted into the pipe at that
// edge. An instruction accepted at edge n sits at stage (now - n); the
// youngest producer is the most recently accepted matching instruction that
// is still within DEPTH stages and newer than the last reset edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_unit;
    localparam int W  = 32;
    localparam int AW = 5;
    localparam int D  = 3;
    localparam int ND = 3;
    localparam int LG = 1024;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    // ---------------- shared stimulus ----------------
    logic              id_valid, id_use_rs, id_use_rt, id_we, id_load, flush;
    logic [AW-1:0]     id_rs, id_rt, id_rd;
    logic [W-1:0]      rf_a, rf_b;
    logic [D*W-1:0]    stage_data;

    pipe_hazard_unit_if #(.WORD_WIDTH(W), .ADDR_W(AW), .DEPTH(D), .CNT_W(16)) if0 ();
    pipe_hazard_unit_if #(.WORD_WIDTH(W), .ADDR_W(AW), .DEPTH(D), .CNT_W(16)) if1 ();
    pipe_hazard_unit_if #(.WORD_WIDTH(W), .ADDR_W(AW), .DEPTH(D), .CNT_W(2))  if2 ();

    assign if0.id_valid = id_valid;   assign if1.id_valid = id_valid;   assign if2.id_valid = id_valid;
    assign if0.id_rs = id_rs;         assign if1.id_rs = id_rs;         assign if2.id_rs = id_rs;
    assign if0.id_rt = id_rt;         assign if1.id_rt = id_rt;         assign if2.id_rt = id_rt;
    assign if0.id_use_rs = id_use_rs; assign if1.id_use_rs = id_use_rs; assign if2.id_use_rs = id_use_rs;
    assign if0.id_use_rt = id_use_rt; assign if1.id_use_rt = id_use_rt; assign if2.id_use_rt = id_use_rt;
    assign if0.id_rd = id_rd;         assign if1.id_rd = id_rd;         assign if2.id_rd = id_rd;
    assign if0.id_we = id_we;         assign if1.id_we = id_we;         assign if2.id_we = id_we;
    assign if0.id_load = id_load;     assign if1.id_load = id_load;     assign if2.id_load = id_load;
    assign if0.flush = flush;         assign if1.flush = flush;         assign if2.flush = flush;
    assign if0.rf_a = rf_a;           assign if1.rf_a = rf_a;           assign if2.rf_a = rf_a;
    assign if0.rf_b = rf_b;           assign if1.rf_b = rf_b;           assign if2.rf_b = rf_b;
    assign if0.stage_data = stage_data;
    assign if1.stage_data = stage_data;
    assign if2.stage_data = stage_data;

    pipe_hazard_unit #(.WORD_WIDTH(W), .ADDR_W(AW), .DEPTH(D), .LOAD_READY(1), .CNT_W(16))
        u0 (.CLK(CLK), .RST(RST), .bus(if0.slave));
    pipe_hazard_unit #(.WORD_WIDTH(W), .ADDR_W(AW), .DEPTH(D), .LOAD_READY(2), .CNT_W(16))
        u1 (.CLK(CLK), .RST(RST), .bus(if1.slave));
    pipe_hazard_unit #(.WORD_WIDTH(W), .ADDR_W(AW), .DEPTH(D), .LOAD_READY(1), .CNT_W(2))
        u2 (.CLK(CLK), .RST(RST), .bus(if2.slave));

    // ---------------- reference model state ----------------
    logic          lg_v  [ND][LG];
    logic [AW-1:0] lg_rd [ND][LG];
    logic          lg_we [ND][LG];
    logic          lg_ld [ND][LG];
    int            cnt_m [ND];
    int            lr_m  [ND] = '{1, 2, 1};
    int            cmax  [ND] = '{65535, 65535, 3};
    logic          es    [ND];
    int            cyc;
    int            last_rst;

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Stage index of the youngest in-flight producer of s, or -1.
    function automatic int youngest(input int d, input logic [AW-1:0] s, input logic use_s);
        for (int age = 0; age < D; age++) begin
            int n;
            n = cyc - age;
            if (n > last_rst) begin
                if (lg_v[d][n % LG] && lg_we[d][n % LG] && lg_rd[d][n % LG] == s
                    && s != '0 && use_s)
                    return age;
            end
        end
        return -1;
    endfunction

    task automatic get_obs(input int d, output logic [W-1:0] oa, output logic [W-1:0] ob,
                           output logic st, output logic pw, output logic iw,
                           output logic [15:0] sc, output logic [D-1:0] sv);
        case (d)
            0: begin oa = if0.op_a; ob = if0.op_b; st = if0.stall; pw = if0.pc_we;
                     iw = if0.ifid_we; sc = if0.stall_cnt; sv = if0.sb_valid; end
            1: begin oa = if1.op_a; ob = if1.op_b; st = if1.stall; pw = if1.pc_we;
                     iw = if1.ifid_we; sc = if1.stall_cnt; sv = if1.sb_valid; end
            default: begin oa = if2.op_a; ob = if2.op_b; st = if2.stall; pw = if2.pc_we;
                     iw = if2.ifid_we; sc = {14'd0, if2.stall_cnt}; sv = if2.sb_valid; end
        endcase
    endtask

    task automatic rand_data();
        stage_data = {$urandom(), $urandom(), $urandom()};
        rf_a = $urandom();
        rf_b = $urandom();
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; applies the ID instruction, waits to
    // mid-cycle and compares every instance against the model.
    task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic urs, input logic urt, input logic [AW-1:0] rd,
                         input logic we, input logic ld, input logic fl, input logic rst);
        logic [W-1:0] oa, ob, ea, eb;
        logic         st, pw, iw;
        logic [15:0]  sc;
        logic [D-1:0] sv, esv;
        int           ya, yb;
        logic         hz;
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_rd = rd; id_we = we; id_load = ld; flush = fl; RST = rst;
        #4;
        for (int d = 0; d < ND; d++) begin
            ya = youngest(d, rs, urs);
            yb = youngest(d, rt, urt);
            ea = (ya < 0) ? rf_a : stage_data[ya*W +: W];
            eb = (yb < 0) ? rf_b : stage_data[yb*W +: W];
            hz = 1'b0;
            if (ya >= 0 && ya < lr_m[d] && lg_ld[d][(cyc - ya) % LG]) hz = 1'b1;
            if (yb >= 0 && yb < lr_m[d] && lg_ld[d][(cyc - yb) % LG]) hz = 1'b1;
            es[d] = v && !fl && hz;
            for (int k = 0; k < D; k++)
                esv[k] = (cyc - k > last_rst) ? lg_v[d][(cyc - k) % LG] : 1'b0;
            get_obs(d, oa, ob, st, pw, iw, sc, sv);
            check($sformatf("u%0d_op_a", d), 64'(oa), 64'(ea));
            check($sformatf("u%0d_op_b", d), 64'(ob), 64'(eb));
            check($sformatf("u%0d_stall", d), 64'(st), 64'(es[d]));
            check($sformatf("u%0d_pc_we", d), 64'(pw), 64'(!es[d]));
            check($sformatf("u%0d_ifid_we", d), 64'(iw), 64'(!es[d]));
            check($sformatf("u%0d_stall_cnt", d), 64'(sc), 64'(cnt_m[d]));
            check($sformatf("u%0d_sb_valid", d), 64'(sv), 64'(esv));
        end
    endtask

    // Records what each instance accepts at the coming edge, then advances.
    task automatic advance();
        for (int d = 0; d < ND; d++) begin
            lg_v [d][(cyc + 1) % LG] = !RST && id_valid && !flush && !es[d];
            lg_rd[d][(cyc + 1) % LG] = id_rd;
            lg_we[d][(cyc + 1) % LG] = id_we;
            lg_ld[d][(cyc + 1) % LG] = id_load;
            if (RST) cnt_m[d] = 0;
            else if (es[d] && cnt_m[d] < cmax[d]) cnt_m[d]++;
        end
        if (RST) last_rst = cyc + 1;
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic step(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic urs, input logic urt, input logic [AW-1:0] rd,
                        input logic we, input logic ld, input logic fl, input logic rst);
        drive(v, rs, rt, urs, urt, rd, we, ld, fl, rst);
        advance();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        RST = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0;
        id_use_rt = 1'b0; id_rd = '0; id_we = 1'b0; id_load = 1'b0; flush = 1'b0;
        rand_data();
        cyc = 0; last_rst = 0;
        for (int d = 0; d < ND; d++) cnt_m[d] = 0;
        @(posedge CLK);
        cyc = 1; last_rst = 1;
        #1;

        // Reset held with a live ID instruction.
        for (int i = 0; i < 2; i++) begin
            rand_data();
            step(1, 5'(i + 1), 5'(i + 2), 1, 1, 5'(i + 1), 1, 1, 0, 1);
        end
        rand_data();
        drive(1, 5'd3, 5'd4, 1, 1, 5'd6, 1, 0, 0, 0);
        check("rst_stall", 64'(if0.stall), 64'd0);
        check("rst_op_a", 64'(if0.op_a), 64'(rf_a));
        advance();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // ALU chain: r3 <- alu, then r4 <- r3 + r1.
        rand_data();
        step(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0);
        rand_data(); stage_data[0 +: W] = 32'h0000_00AA;
        drive(1, 5'd3, 5'd1, 1, 1, 5'd4, 1, 0, 0, 0);
        check("alu_fwd_e0", 64'(if0.op_a), 64'h0000_00AA);
        check("alu_nostall", 64'(if0.stall), 64'd0);
        advance();
        rand_data();
        step(1, 5'd10, 5'd10, 1, 1, 5'd11, 1, 0, 0, 0);
        rand_data(); stage_data[2*W +: W] = 32'h0000_00AA;
        drive(1, 5'd3, 5'd0, 1, 0, 5'd12, 1, 0, 0, 0);
        check("alu_fwd_wb", 64'(if0.op_a), 64'h0000_00AA);
        advance();

        // Load-use from a clean counter.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        rand_data();
        step(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 0, 0);
        rand_data();
        drive(1, 5'd5, 5'd2, 1, 1, 5'd6, 1, 0, 0, 0);
        check("lu_stall", 64'(if0.stall), 64'd1);
        advance();
        rand_data(); stage_data[W +: W] = 32'h1234_5678;
        drive(1, 5'd5, 5'd2, 1, 1, 5'd6, 1, 0, 0, 0);
        check("lu_fwd_e1", 64'(if0.op_a), 64'h1234_5678);
        check("lu_bubble", 64'(if0.sb_valid[0]), 64'd0);
        check("lu_lr2_stall", 64'(if1.stall), 64'd1);
        advance();
        rand_data();
        step(1, 5'd5, 5'd2, 1, 1, 5'd6, 1, 0, 0, 0);
        rand_data();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lu_cnt_lr1", 64'(if0.stall_cnt), 64'd1);
        check("lu_cnt_lr2", 64'(if1.stall_cnt), 64'd2);

        // Priority: r7 in entries 0 and 2, then r0 never forwards.
        rand_data();
        step(1, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 5'd12, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0);
        rand_data();
        stage_data = {32'h0000_0022, 32'h0000_0033, 32'h0000_0011};
        drive(1, 5'd7, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0);
        check("prio_young", 64'(if0.op_a), 64'h0000_0011);
        advance();
        rand_data();
        drive(1, 5'd0, 5'd0, 1, 1, 5'd13, 1, 0, 0, 0);
        check("r0_no_fwd", 64'(if0.op_a), 64'(rf_a));
        advance();

        // Flush in the hazard cycle.
        rand_data();
        step(1, 0, 0, 0, 0, 5'd5, 1, 1, 0, 0);
        rand_data();
        drive(1, 5'd5, 5'd0, 1, 0, 5'd9, 1, 0, 1, 0);
        check("flush_nostall", 64'(if0.stall), 64'd0);
        advance();
        rand_data();
        drive(1, 5'd9, 5'd0, 1, 0, 5'd14, 1, 0, 0, 0);
        check("flush_untracked", 64'(if0.op_a), 64'(rf_a));
        advance();

        // Five load-use stalls, then reset with live entries.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            rand_data();
            step(1, 0, 0, 0, 0, 5'd5, 1, 1, 0, 0);
            rand_data();
            step(1, 5'd5, 5'd5, 1, 1, 5'd6, 1, 0, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("sat_cnt", 64'(if2.stall_cnt), 64'd3);
        rand_data();
        step(1, 0, 0, 0, 0, 5'd8, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 5'd8, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 5'd8, 1, 1, 0, 1);
        rand_data();
        drive(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 0);
        check("rst_mid_op_a", 64'(if2.op_a), 64'(rf_a));
        check("rst_mid_cnt", 64'(if2.stall_cnt), 64'd0);
        advance();

        // Random traffic on a small register set to provoke frequent hazards.
        for (int i = 0; i < 400; i++) begin
            rand_data();
            step($urandom_range(0, 7) != 0,
                 5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 6)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 49) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
